disp14_scan_ctrl: RTL and testbench

//  Scan controller for the 12-digit, 14-segment multiplexed display.
//  - Owns a 12-entry glyph buffer (14-bit segment patterns), loaded over a valid/ready write port.
//  - Drives one-hot digit select and segment pattern with programmable slot time and anti-ghost blanking.
//  - Optionally scrolls the message left; arbitrates the single-port buffer between host writes and display fetch.

---
 rtl/disp14_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_disp14_scan_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/disp14_scan_ctrl.sv
// Scan controller for a multiplexed 14-segment display.
// Holds a glyph buffer written by the host, walks a one-hot digit select
// with a blanking gap at the start of every slot, and optionally scrolls
// the message left one digit every SCROLL_FRAMES frames.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | pc < BLANK: digit lines and segments dark (anti-ghosting)
// ST_ON    | pc >= BLANK: selected digit driven with the staged glyph
module disp14_scan_ctrl #(
    parameter int N_DIG         = 12,
    parameter int SEG_W         = 14,
    parameter int DIV           = 1000,
    parameter int BLANK         = 8,
    parameter int SCROLL_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [3:0]         wr_addr,
    input  logic [SEG_W-1:0]   wr_data,
    input  logic               scroll_en,
    input  logic               blank,
    output logic [N_DIG-1:0]   sel,
    output logic [SEG_W-1:0]   segm,
    output logic               frame_tick
);

    localparam int PC_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int FC_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(DIV - 1);
    localparam logic [PC_W-1:0]  PC_BLANK = PC_W'(BLANK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
    localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(N_DIG);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(SCROLL_FRAMES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] offset_q, offset_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic [SEG_W-1:0] glyph_q, glyph_d;
    logic [SEG_W-1:0] glyph_buf_q [N_DIG];
    logic [SEG_W-1:0] glyph_buf_d [N_DIG];

    logic [N_DIG-1:0] sel_q, sel_d;
    logic [SEG_W-1:0] segm_q, segm_d;
    logic             frame_tick_q, frame_tick_d;
    logic             wr_ready_q, wr_ready_d;

    logic             fetch;
    logic             tick;
    logic             wr_fire;
    logic             addr_ok;
    logic [IDX_W-1:0] idx_next;
    logic [IDX_W:0]   fetch_sum;
    logic [IDX_W-1:0] fetch_addr;

    assign fetch    = (pc_q == PC_LAST);
    assign tick     = fetch && (idx_q == IDX_LAST);
    assign idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    // wr_ready_q is low exactly in the fetch cycle, so a write can never
    // collide with the buffer read of the fetch.
    assign wr_fire  = wr_valid && wr_ready_q;
    assign addr_ok  = ({1'b0, wr_addr} < 5'(N_DIG));

    // Scan timing, scroll bookkeeping, glyph fetch and host buffer writes.
    always_comb begin
        pc_d        = fetch ? '0 : pc_q + 1'b1;
        idx_d       = fetch ? idx_next : idx_q;
        fc_d        = fc_q;
        offset_d    = offset_q;
        glyph_d     = glyph_q;
        glyph_buf_d = glyph_buf_q;
        fetch_sum   = '0;
        fetch_addr  = '0;

        if (!scroll_en) begin
            fc_d = '0;
        end else if (tick) begin
            if (fc_q == FC_LAST) begin
                fc_d     = '0;
                offset_d = (offset_q == IDX_LAST) ? '0 : offset_q + 1'b1;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end

        // The fetch uses the offset after this cycle's scroll step so the
        // new frame starts already shifted.
        if (fetch) begin
            fetch_sum  = {1'b0, idx_next} + {1'b0, offset_d};
            fetch_addr = (fetch_sum >= N_EXT) ? IDX_W'(fetch_sum - N_EXT)
                                              : IDX_W'(fetch_sum);
            glyph_d    = glyph_buf_q[fetch_addr];
        end

        // Out-of-range addresses complete the handshake but are dropped.
        if (wr_fire && addr_ok) begin
            glyph_buf_d[wr_addr] = wr_data;
        end
    end

    // Slot FSM next state and registered output values.
    always_comb begin
        state_d      = state_q;
        sel_d        = '0;
        segm_d       = '0;
        frame_tick_d = (pc_d == PC_LAST) && (idx_d == IDX_LAST);
        wr_ready_d   = (pc_d != PC_LAST);

        case (state_q)
            ST_BLANK: if (pc_d >= PC_BLANK) state_d = ST_ON;
            ST_ON:    if (pc_d <  PC_BLANK) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

        // Outputs trail the slot state by one cycle; blank gates them
        // without disturbing the scan.
        if (state_q == ST_ON && !blank) begin
            sel_d  = N_DIG'(1) << idx_q;
            segm_d = glyph_q;
        end
    end

    // State, counters, buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            pc_q         <= '0;
            idx_q        <= '0;
            offset_q     <= '0;
            fc_q         <= '0;
            glyph_q      <= '0;
            sel_q        <= '0;
            segm_q       <= '0;
            frame_tick_q <= 1'b0;
            wr_ready_q   <= 1'b0;
            for (int i = 0; i < N_DIG; i++) begin
                glyph_buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            offset_q     <= offset_d;
            fc_q         <= fc_d;
            glyph_q      <= glyph_d;
            sel_q        <= sel_d;
            segm_q       <= segm_d;
            frame_tick_q <= frame_tick_d;
            wr_ready_q   <= wr_ready_d;
            glyph_buf_q  <= glyph_buf_d;
        end
    end

    assign sel        = sel_q;
    assign segm       = segm_q;
    assign frame_tick = frame_tick_q;
    assign wr_ready   = wr_ready_q;

endmodule

// File: tb/tb_disp14_scan_ctrl.sv
// Bench for disp14_scan_ctrl with a short slot time. A reference model
// tracks scan position from the cycle count since reset and keeps its own
// copy of the glyph buffer, offset and frame count.
module tb_disp14_scan_ctrl;

    localparam int N   = 12;
    localparam int SW  = 14;
    localparam int DIV = 4;
    localparam int BLK = 1;
    localparam int SF  = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wr_valid;
    logic           wr_ready;
    logic [3:0]     wr_addr;
    logic [SW-1:0]  wr_data;
    logic           scroll_en;
    logic           blank;
    logic [N-1:0]   sel;
    logic [SW-1:0]  segm;
    logic           frame_tick;

    disp14_scan_ctrl #(
        .N_DIG(N), .SEG_W(SW), .DIV(DIV), .BLANK(BLK), .SCROLL_FRAMES(SF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .scroll_en(scroll_en), .blank(blank),
        .sel(sel), .segm(segm), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // reference model state
    int            cyc;
    int            off;
    int            fc;
    logic [SW-1:0] mbuf [N];
    logic [SW-1:0] m_glyph;
    logic          m_rdy;
    logic          acc;
    logic [N-1:0]  e_sel;
    logic [SW-1:0] e_segm;
    logic          e_tick;
    logic [SW-1:0] seen3;

    logic [SW-1:0] tab [N] = '{14'h00F9, 14'h0071, 14'h00F7, 14'h128F,
                               14'h0038, 14'h00F9, 14'h00ED, 14'h00ED,
                               14'h0000, 14'h0006, 14'h00FF, 14'h0C3F};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ntests++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        cyc = 0; off = 0; fc = 0;
        m_glyph = '0; m_rdy = 1'b0; acc = 1'b0;
        for (int k = 0; k < N; k++) mbuf[k] = '0;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then compare all outputs just after the edge.
    task automatic step();
        int p, i;
        @(posedge clk);
        p   = cyc % DIV;
        i   = (cyc / DIV) % N;
        acc = wr_valid && m_rdy;
        if (blank || p < BLK) begin
            e_sel = '0; e_segm = '0;
        end else begin
            e_sel = N'(1) << i; e_segm = m_glyph;
        end
        if (!scroll_en) fc = 0;
        else if (p == DIV-1 && i == N-1) begin
            if (fc == SF-1) begin fc = 0; off = (off + 1) % N; end
            else fc++;
        end
        if (p == DIV-1) m_glyph = mbuf[((i + 1) % N + off) % N];
        if (acc && wr_addr < 4'(N)) mbuf[wr_addr] = wr_data;
        cyc++;
        p      = cyc % DIV;
        i      = (cyc / DIV) % N;
        m_rdy  = (p != DIV-1);
        e_tick = (p == DIV-1) && (i == N-1);
        #1;
        chk("sel", 32'(sel), 32'(e_sel));
        chk("segm", 32'(segm), 32'(e_segm));
        chk("frame_tick", 32'(frame_tick), 32'(e_tick));
        chk("wr_ready", 32'(wr_ready), 32'(m_rdy));
    endtask

    task automatic wr(input logic [3:0] a, input logic [SW-1:0] dt);
        int n = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = dt;
        do begin step(); n++; end while (!acc && n < 8);
        wr_valid = 1'b0;
        if (!acc) chk("wr_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin step(); n++; end while (frame_tick !== 1'b1 && n < 100);
        chk("tick_wait", 32'(frame_tick), 32'd1);
    endtask

    // Called right after a frame_tick: checks one whole displayed frame.
    task automatic chk_digits(input int o);
        logic [N-1:0] seen = '0;
        step();
        for (int s = 0; s < DIV*N; s++) begin
            step();
            for (int d = 0; d < N; d++) begin
                if (sel == N'(1) << d) begin
                    chk("digit_glyph", 32'(segm), 32'(mbuf[(d + o) % N]));
                    seen[d] = 1'b1;
                    if (d == 3) seen3 = segm;
                end
            end
        end
        chk("digits_seen", 32'(seen), 32'(12'hFFF));
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        scroll_en = 1'b0; blank = 1'b0; seen3 = '0;
        model_reset();

        // 1: reset state and bare scan
        #12;
        chk("rst_sel", 32'(sel), 0);
        chk("rst_segm", 32'(segm), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        chk("rst_ready", 32'(wr_ready), 0);
        rst_n = 1'b1;
        #1;
        step(); chk("t1_c1", 32'(sel), 0);
        step(); chk("t1_c2", 32'(sel), 32'h001);
        step(); chk("t1_c3", 32'(sel), 32'h001);
        step(); chk("t1_c4", 32'(sel), 32'h001);
        step(); chk("t1_c5", 32'(sel), 0);
        step(); chk("t1_c6", 32'(sel), 32'h002);
        cnt = 0;
        for (int s = 0; s < DIV*N; s++) begin
            step();
            if (frame_tick) cnt++;
        end
        chk("t1_ticks_per_frame", 32'(cnt), 1);

        // 2: load message, check one frame
        for (int d = 0; d < N; d++) wr(4'(d), tab[d]);
        wait_tick();
        chk_digits(0);

        // 3: write held across a fetch cycle
        for (int k = 0; k < DIV && (cyc % DIV) != DIV-1; k++) step();
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 14'h2A5A;
        chk("t3_ready_fetch", 32'(wr_ready), 0);
        step();
        chk("t3_ready_next", 32'(wr_ready), 1);
        step();
        wr_valid = 1'b0;
        wait_tick();
        chk_digits(0);
        chk("t3_digit3", 32'(seen3), 32'h2A5A);

        // 4: scroll one step after two ticks, back home after 24
        scroll_en = 1'b1;
        wait_tick(); wait_tick();
        chk_digits(1);
        for (int t = 0; t < 21; t++) wait_tick();
        chk_digits(0);
        scroll_en = 1'b0;

        // 5: blank mid-frame
        repeat (17) step();
        blank = 1'b1;
        for (int s = 0; s < 10; s++) begin
            step();
            chk("t5_sel_dark", 32'(sel), 0);
            chk("t5_segm_dark", 32'(segm), 0);
        end
        blank = 1'b0;
        repeat (DIV*N) step();

        // random writes, scroll and blank against the model
        for (int k = 0; k < 400; k++) begin
            if (!wr_valid && $urandom_range(0, 3) == 0) begin
                wr_valid = 1'b1;
                wr_addr  = 4'($urandom_range(0, 15));
                wr_data  = 14'($urandom);
            end
            if ($urandom_range(0, 63) == 0) scroll_en = ~scroll_en;
            blank = ($urandom_range(0, 15) == 0);
            step();
            if (acc) wr_valid = 1'b0;
        end
        for (int k = 0; k < 8 && wr_valid; k++) begin
            step();
            if (acc) wr_valid = 1'b0;
        end
        wr_valid = 1'b0; scroll_en = 1'b0; blank = 1'b0;

        // 6: out-of-range writes are accepted and dropped
        wr(4'd12, 14'h3FFF);
        wr(4'd15, 14'h1234);
        wait_tick();
        chk_digits(off);

        // async reset in the middle of an ON phase
        for (int k = 0; k < 8 && sel == '0; k++) step();
        chk("t6_on_before_rst", 32'(sel != '0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_sel", 32'(sel), 0);
        chk("t6_async_segm", 32'(segm), 0);
        chk("t6_async_ready", 32'(wr_ready), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        wait_tick();
        chk_digits(0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
